divmod_seq: RTL and testbench

Parametrised multi-cycle integer divider producing quotient and remainder of two WIDTH-bit operands, one quotient bit per clock, via restoring shift-subtract.
- Supersedes the fixed 32-bit, free-running modulo unit. Adds a start/done handshake, division as well as modulo, signed operation and divide-by-zero reporting.
- Sits beside the ALU in the datapath.
- The control unit stalls on `busy` and captures `result` on `done`.

---
 rtl/divmod_seq.sv | 139 +++++++++++++
 tb/tb_divmod_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/divmod_seq.sv
// Sequential restoring divider: one quotient bit per clock.
// Signed mode divides magnitudes, then fixes signs in one extra cycle.
module divmod_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, dvd, dvs;
  logic             op_q, sgn_q, qneg_q, aneg_q;
  logic             busy_nx, done_nx;
  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, diff;
  logic             fits;
  logic [WIDTH-1:0] q_fix, r_fix;

  always_comb begin
    a_neg   = is_signed & a[WIDTH-1];
    b_neg   = is_signed & b[WIDTH-1];
    a_mag   = a_neg ? -a : a;
    b_mag   = b_neg ? -b : b;
    b_zero  = (b == '0);
    shifted = {rem, dvd[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    // rem < dvs keeps diff within WIDTH bits when it fits
    fits    = ~diff[WIDTH];
    q_fix   = (sgn_q && qneg_q) ? -dvd : dvd;
    r_fix   = (sgn_q && aneg_q) ? -rem : rem;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = b_zero ? DONE : CALC;
      CALC: if (cnt == CW'(1)) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy_nx = (state_nx == CALC) || (state_nx == FIX);
    done_nx = (state_nx == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nx;
      done <= done_nx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      rem         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      op_q        <= 1'b0;
      sgn_q       <= 1'b0;
      qneg_q      <= 1'b0;
      aneg_q      <= 1'b0;
      result      <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            if (b_zero) begin
              quotient    <= '1;
              remainder   <= a;
              result      <= op ? '1 : a;
              div_by_zero <= 1'b1;
            end else begin
              sgn_q  <= is_signed;
              aneg_q <= a_neg;
              qneg_q <= a_neg ^ b_neg;
              dvd    <= a_mag;
              dvs    <= b_mag;
              rem    <= '0;
              cnt    <= CW'(WIDTH);
            end
          end
        end
        CALC: begin
          rem <= fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
          dvd <= {dvd[WIDTH-2:0], fits};
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          quotient    <= q_fix;
          remainder   <= r_fix;
          result      <= op_q ? q_fix : r_fix;
          div_by_zero <= 1'b0;
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divmod_seq.sv
// Bench for divmod_seq: vector table, scoreboard queue,
// busy/reset corner sequences and a WIDTH=8 instance.
module tb_divmod_seq;

  typedef struct {
    logic        op;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic        sgn = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] result, quotient, remainder;
  logic        busy, done, dbz;

  logic        start8 = 1'b0;
  logic        op8 = 1'b0;
  logic        sgn8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic [7:0]  result8, quotient8, remainder8;
  logic        busy8, done8, dbz8;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   e0 = 0;
  vec_t scb[$];
  vec_t tbl[12];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  divmod_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start),
    .op(op), .is_signed(sgn), .a(a), .b(b),
    .result(result), .quotient(quotient),
    .remainder(remainder), .busy(busy),
    .done(done), .div_by_zero(dbz)
  );

  divmod_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8),
    .op(op8), .is_signed(sgn8), .a(a8), .b(b8),
    .result(result8), .quotient(quotient8),
    .remainder(remainder8), .busy(busy8),
    .done(done8), .div_by_zero(dbz8)
  );

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic o, input logic s,
                              input logic [31:0] x,
                              input logic [31:0] y,
                              input logic [31:0] q,
                              input logic [31:0] r,
                              input logic z);
    vec_t v;
    v.op = o; v.sgn = s; v.a = x; v.b = y;
    v.q = q; v.r = r; v.dbz = z;
    return v;
  endfunction

  // Reference model for random vectors
  function automatic vec_t model(input logic o, input logic s,
                                 input logic [31:0] x,
                                 input logic [31:0] y);
    vec_t v;
    logic signed [31:0] sx, sy;
    v.op = o; v.sgn = s; v.a = x; v.b = y; v.dbz = 1'b0;
    sx = x; sy = y;
    if (y == 0) begin
      v.q = '1; v.r = x; v.dbz = 1'b1;
    end else if (s) begin
      v.q = sx / sy; v.r = sx % sy;
    end else begin
      v.q = x / y; v.r = x % y;
    end
    return v;
  endfunction

  task automatic launch(input vec_t v);
    @(negedge clk);
    op = v.op; sgn = v.sgn; a = v.a; b = v.b;
    start = 1'b1;
    scb.push_back(v);
    @(posedge clk);
    #1;
    start = 1'b0;
    e0 = cyc;
    chk("busy_after_e0", busy, (v.b != 0));
  endtask

  task automatic wait_check(input int exp_lat, input string tag);
    vec_t e;
    int   lat;
    while (!done && (cyc - e0) < 100) begin
      @(posedge clk);
      #1;
    end
    lat = cyc - e0 + 1;
    if (scb.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s_scb: got empty queue, want entry", tag);
    end else if (!done) begin
      e = scb.pop_front();
      n_vec++; n_err++;
      $display("FAIL %s_timeout: got no done, want done", tag);
    end else begin
      e = scb.pop_front();
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_q"}, quotient, e.q);
      chk({tag, "_r"}, remainder, e.r);
      chk({tag, "_res"}, result, e.op ? e.q : e.r);
      chk({tag, "_dbz"}, dbz, e.dbz);
      chk({tag, "_busy"}, busy, 0);
    end
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, done, 0);
  endtask

  task automatic run(input vec_t v, input string tag);
    launch(v);
    wait_check((v.b == 0) ? 1 : 34, tag);
  endtask

  initial begin
    int   extra;
    int   t;
    vec_t v;
    logic [31:0] hold;

    tbl[0]  = mk(0, 0, 25, 8, 3, 1, 0);
    tbl[1]  = mk(0, 0, 40, 12, 3, 4, 0);
    tbl[2]  = mk(1, 0, 45, 15, 3, 0, 0);
    tbl[3]  = mk(1, 1, 32'hFFFF_FFF9, 2,
                 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
    tbl[4]  = mk(0, 1, 7, 32'hFFFF_FFFE,
                 32'hFFFF_FFFD, 1, 0);
    tbl[5]  = mk(1, 1, 32'h8000_0000, 32'hFFFF_FFFF,
                 32'h8000_0000, 0, 0);
    tbl[6]  = mk(1, 0, 30, 0, 32'hFFFF_FFFF, 30, 1);
    tbl[7]  = mk(0, 0, 100, 7, 14, 2, 0);
    tbl[8]  = mk(1, 0, 32'hFFFF_FFFF, 1,
                 32'hFFFF_FFFF, 0, 0);
    tbl[9]  = mk(1, 0, 5, 7, 0, 5, 0);
    tbl[10] = mk(0, 1, 32'hFFFF_FFF9, 32'hFFFF_FFFE,
                 3, 32'hFFFF_FFFF, 0);
    tbl[11] = mk(0, 1, 32'hFFFF_FFEC, 0,
                 32'hFFFF_FFFF, 32'hFFFF_FFEC, 1);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", dbz, 0);
    chk("rst8_outs", {result8, quotient8, remainder8,
                      busy8, done8, dbz8}, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run(tbl[i], $sformatf("tbl%0d", i));
      hold = result;
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_hold", i), result, hold);
    end

    // start during CALC must be dropped
    launch(mk(1, 0, 30, 10, 3, 0, 0));
    repeat (4) @(posedge clk);
    @(negedge clk);
    a = 45; b = 5; start = 1'b1;
    @(negedge clk);
    start = 1'b0; b = 0;
    wait_check(34, "busy");
    extra = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    chk("busy_no_second_done", extra, 0);

    for (int i = 0; i < 6; i++) begin
      logic s;
      logic [31:0] x, y;
      s = i[0];
      x = $urandom;
      y = $urandom >> $urandom_range(0, 28);
      if (y == 0) y = 3;
      if (s && x == 32'h8000_0000 && y == '1) y = 5;
      v = model(i[1], s, x, y);
      run(v, $sformatf("rnd%0d", i));
    end

    // asynchronous reset mid-CALC
    launch(mk(0, 0, 100, 7, 14, 2, 0));
    repeat (9) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("mid_rst_outs", {result, quotient, remainder}, 0);
    chk("mid_rst_ctl", {busy, done, dbz}, 0);
    v = scb.pop_front();
    extra = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    chk("mid_rst_no_done", extra, 0);
    run(mk(0, 0, 100, 7, 14, 2, 0), "after_rst");

    @(negedge clk);
    a8 = 8'd200; b8 = 8'd7; op8 = 1'b1; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    t = cyc;
    while (!done8 && (cyc - t) < 40) begin
      @(posedge clk);
      #1;
    end
    chk("w8_done", done8, 1);
    chk("w8_lat", cyc - t + 1, 10);
    chk("w8_result", result8, 28);
    chk("w8_rem", remainder8, 4);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
